// File: rtl/quad_pkg.sv
// Shared constants and FSM encoding for the quadruple-counter array loader.
package quad_pkg;

    localparam int N  = 100;
    localparam int KW = 8;
    localparam int CW = 16;
    localparam int NB = (N + 7) / 8;

    typedef enum logic [1:0] {
        LOAD_K   = 2'd0,
        LOAD_ARR = 2'd1,
        SETTLE   = 2'd2,
        RESULT   = 2'd3
    } state_e;

endpackage

// File: rtl/quad_array_loader.sv
// Byte-stream loader that feeds k and a packed array to the quadruple counter and returns its count.
// State | meaning: LOAD_K take k | LOAD_ARR pack array bytes | SETTLE hold array stable | RESULT offer count.
module quad_array_loader
    import quad_pkg::*;
#(
    parameter int N      = quad_pkg::N,
    parameter int KW     = quad_pkg::KW,
    parameter int CW     = quad_pkg::CW,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic [N-1:0]  array_out,
    output logic [KW-1:0] k_out,
    output logic          array_valid,
    input  logic [CW-1:0] count_in,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [CW-1:0] result
);

    localparam int NB = (N + 7) / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW = 4;
    localparam logic [IW-1:0] LAST_IDX    = IW'(NB - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  array_q, array_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] result_q, result_d;
    logic          in_ready_q, in_ready_d;
    logic          array_valid_q, array_valid_d;
    logic          result_valid_q, result_valid_d;
    logic          xfer;
    logic          last_byte;
    logic          settle_done;
    logic          res_hs;

    assign xfer        = in_valid && in_ready_q;
    assign last_byte   = (idx_q == LAST_IDX);
    assign settle_done = (cnt_q == SETTLE_LAST);
    assign res_hs      = result_valid_q && result_ready;

    // The parameter SETTLE shadows the enum literal, so the state is named through the package.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_K:           if (xfer)              state_d = LOAD_ARR;
            LOAD_ARR:         if (xfer && last_byte) state_d = quad_pkg::SETTLE;
            quad_pkg::SETTLE: if (settle_done)       state_d = RESULT;
            RESULT:           if (res_hs)            state_d = LOAD_K;
            default:                                 state_d = LOAD_K;
        endcase
    end

    // Handshake flags are decoded from the next state so they leave the block as flops.
    always_comb begin
        in_ready_d     = (state_d == LOAD_K) || (state_d == LOAD_ARR);
        array_valid_d  = (state_d == quad_pkg::SETTLE) || (state_d == RESULT);
        result_valid_d = (state_d == RESULT);
    end

    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        array_d  = array_q;
        k_d      = k_q;
        result_d = result_q;
        case (state_q)
            LOAD_K: begin
                if (xfer) begin
                    k_d   = in_data[KW-1:0];
                    idx_d = '0;
                end
            end
            LOAD_ARR: begin
                if (xfer) begin
                    // Bits of the final byte that land at or above N have no target and drop out.
                    for (int j = 0; j < N; j++) begin
                        if (idx_q == IW'(j / 8)) begin
                            array_d[j] = in_data[j[2:0]];
                        end
                    end
                    if (last_byte) begin
                        cnt_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            quad_pkg::SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (settle_done) begin
                    result_d = count_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LOAD_K;
            idx_q          <= '0;
            cnt_q          <= '0;
            array_q        <= '0;
            k_q            <= '0;
            result_q       <= '0;
            in_ready_q     <= 1'b0;
            array_valid_q  <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            array_q        <= array_d;
            k_q            <= k_d;
            result_q       <= result_d;
            in_ready_q     <= in_ready_d;
            array_valid_q  <= array_valid_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign array_out    = array_q;
    assign k_out        = k_q;
    assign array_valid  = array_valid_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_quad_array_loader.sv
// Randomized self-checking bench for quad_array_loader against a frame-level reference model.
module tb_quad_array_loader;

    localparam int N      = 100;
    localparam int KW     = 8;
    localparam int CW     = 16;
    localparam int SETTLE = 2;
    localparam int NB     = 13;

    typedef logic [7:0] frame_t [NB];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic [N-1:0]  array_out;
    logic [KW-1:0] k_out;
    logic          array_valid;
    logic [CW-1:0] count_in;
    logic          result_valid;
    logic          result_ready;
    logic [CW-1:0] result;
    logic [15:0]   salt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quad_array_loader #(.N(N), .KW(KW), .CW(CW), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .array_out    (array_out),
        .k_out        (k_out),
        .array_valid  (array_valid),
        .count_in     (count_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result)
    );

    // Stand-in for the combinational counter: any fixed mix of array, k and a per-frame salt.
    function automatic logic [15:0] stub(input logic [N-1:0] a, input logic [7:0] k, input logic [15:0] s);
        return a[15:0] ^ a[99:84] ^ {k, ~k} ^ s ^ {4'h0, a[59:48]};
    endfunction

    assign count_in = stub(array_out, k_out, salt);

    // Whole frame as one little-endian number, then keep the low N bits.
    function automatic logic [N-1:0] ref_array(input frame_t b);
        logic [NB*8-1:0] acc;
        acc = '0;
        for (int i = NB - 1; i >= 0; i--) acc = {acc[NB*8-9:0], b[i]};
        return acc[N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit done;
        done = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("rdy_timeout", 128'(done), 128'(1));
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_idle_reset();
        chk("rst_rdy",  128'(in_ready),     128'(0));
        chk("rst_av",   128'(array_valid),  128'(0));
        chk("rst_rv",   128'(result_valid), 128'(0));
        chk("rst_res",  128'(result),       128'(0));
        chk("rst_k",    128'(k_out),        128'(0));
        chk("rst_arr",  128'(array_out),    128'(0));
    endtask

    task automatic run_frame(input logic [7:0] k, input frame_t b, input bit gap, input int hold,
                             input bit rr_early, input bit early_next, input logic [7:0] next_k);
        logic [N-1:0] exp_arr;
        exp_arr = ref_array(b);
        salt    = 16'($urandom);
        if (rr_early) result_ready = 1'b1;
        send_byte(k, 1'b0);
        chk("k_latch", 128'(k_out),       128'(k));
        chk("av_load", 128'(array_valid), 128'(0));
        for (int i = 0; i < NB; i++) send_byte(b[i], gap);
        result_ready = 1'b0;
        chk("av_rise",    128'(array_valid),  128'(1));
        chk("rdy_settle", 128'(in_ready),     128'(0));
        for (int c = 1; c < SETTLE; c++) begin
            @(posedge clk); #1;
            chk("rv_early", 128'(result_valid), 128'(0));
        end
        @(posedge clk); #1;
        chk("rv_lat", 128'(result_valid), 128'(1));
        chk("result", 128'(result),       128'(stub(exp_arr, k, salt)));
        chk("array",  128'(array_out),    128'(exp_arr));
        chk("k_out",  128'(k_out),        128'(k));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("rv_hold",  128'(result_valid), 128'(1));
            chk("rdy_hold", 128'(in_ready),     128'(0));
            chk("arr_hold", 128'(array_out),    128'(exp_arr));
        end
        result_ready = 1'b1;
        if (early_next) begin
            in_valid = 1'b1;
            in_data  = next_k;
        end
        @(negedge clk);
        chk("rdy_hs", 128'(in_ready),     128'(0));
        chk("rv_hs",  128'(result_valid), 128'(1));
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("rv_clr",    128'(result_valid), 128'(0));
        chk("av_clr",    128'(array_valid),  128'(0));
        chk("rdy_after", 128'(in_ready),     128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        frame_t fb;
        logic [7:0] kr;

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        result_ready = 1'b0;
        salt         = '0;
        #12;
        check_idle_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones frame.
        for (int i = 0; i < NB; i++) fb[i] = 8'hFF;
        run_frame(8'h03, fb, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        chk("all_ones", 128'(array_out), 128'({N{1'b1}}));

        // Only the low nibble of the last byte is kept.
        for (int i = 0; i < NB; i++) fb[i] = 8'h00;
        fb[NB-1] = 8'hA5;
        run_frame(8'($urandom), fb, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        chk("clip", 128'(array_out), 128'({4'h5, 96'h0}));

        // Gapped input and a long-stalled host.
        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
        run_frame(8'($urandom), fb, 1'b1, 10, 1'b1, 1'b0, 8'h00);

        // Abort a frame with reset between edges.
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_idle_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
        run_frame(8'($urandom), fb, 1'b0, 2, 1'b0, 1'b1, 8'h07);

        // Next k waits on the wire during the handshake and must not be taken early.
        for (int i = 0; i < NB; i++) fb[i] = 8'h00;
        fb[0] = 8'h01;
        run_frame(8'h07, fb, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        chk("b2b_arr", 128'(array_out), 128'(1));
        chk("b2b_k",   128'(k_out),     128'(7));

        for (int f = 0; f < 8; f++) begin
            kr = 8'($urandom);
            for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
            run_frame(kr, fb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
